// File: rtl/dcache_defs.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM encoding and helpers for deriving address-field widths.
package dcache_defs;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    function automatic int word_bits_f(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits_f(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits_f(input int addr_width, input int lines, input int line_words);
        return addr_width - 2 - $clog2(line_words) - $clog2(lines);
    endfunction

    localparam int WORD_BITS  = word_bits_f(4);
    localparam int INDEX_BITS = index_bits_f(64);
    localparam int TAG_BITS   = tag_bits_f(32, 64, 4);

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: combinational lookup, synchronous writes,
// synchronous active-low clear of all valid bits.
module dcache_store
    import dcache_defs::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32,
    localparam int WB = word_bits_f(LINE_WORDS),
    localparam int IB = index_bits_f(LINES),
    localparam int TB = tag_bits_f(ADDR_WIDTH, LINES, LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IB-1:0] index,
    input  logic [WB-1:0] word,
    input  logic [TB-1:0] tag,
    input  logic          clr,
    input  logic          set,
    input  logic          data_we,
    input  logic [WB-1:0] wword,
    input  logic [31:0]   wdata,
    output logic          hit,
    output logic [31:0]   rdata
);

    logic [LINES-1:0] valid;
    logic [TB-1:0]    tags [LINES];
    logic [31:0]      data [LINES][LINE_WORDS];

    assign hit   = valid[index] && (tags[index] == tag);
    assign rdata = data[index][word];

    always_ff @(posedge clk) begin
        if (!rst)
            valid <= '0;
        else if (set)
            valid[index] <= 1'b1;
        else if (clr)
            valid[index] <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (set)
            tags[index] <= tag;
        if (data_we)
            data[index][wword] <= wdata;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// read hits answer combinationally; misses and writes go through req/ack.
module dcache_ctrl
    import dcache_defs::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam int WB = word_bits_f(LINE_WORDS);
    localparam int IB = index_bits_f(LINES);
    localparam int TB = tag_bits_f(ADDR_WIDTH, LINES, LINE_WORDS);

    logic [1:0]    state;
    logic [WB-1:0] cnt;
    logic [31:0]   dout_r;

    logic [WB-1:0] word;
    logic [IB-1:0] index;
    logic [TB-1:0] tag;
    logic          hit, clr, set, data_we, last, rd;
    logic [WB-1:0] wword;
    logic [31:0]   wdata, rdata;
    logic          unused_ok;

    assign word      = addr[WB+1:2];
    assign index     = addr[WB+2 +: IB];
    assign tag       = addr[ADDR_WIDTH-1 -: TB];
    assign unused_ok = ^addr[1:0];

    assign rd   = cs & ren & ~wen;
    assign last = (cnt == WB'(LINE_WORDS - 1));

    // Store updates are gated by rst so an ack arriving during reset is dropped.
    assign clr     = rst & (state == S_IDLE) & rd & ~hit;
    assign set     = rst & (state == S_FILL) & mem_ack & last;
    assign data_we = rst & mem_ack & ((state == S_FILL) | ((state == S_WRITE) & hit));
    assign wword   = (state == S_FILL) ? cnt : word;
    assign wdata   = (state == S_FILL) ? mem_rdata : din;

    dcache_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .index   (index),
        .word    (word),
        .tag     (tag),
        .clr     (clr),
        .set     (set),
        .data_we (data_we),
        .wword   (wword),
        .wdata   (wdata),
        .hit     (hit),
        .rdata   (rdata)
    );

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        dout      = dout_r;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    stall = cs & (wen | (ren & ~hit));
                    if (rd && hit)
                        dout = rdata;
                end
                S_FILL: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {tag, index, cnt, 2'b00};
                end
                S_WRITE: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata = din;
                end
                default: begin
                    if (rd)
                        dout = rdata;
                end
            endcase
        end else begin
            dout = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dout_r <= '0;
        end else begin
            dout_r <= dout;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (cs && wen)
                        state <= S_WRITE;
                    else if (cs && ren && !hit)
                        state <= S_FILL;
                end
                S_FILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last)
                            state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (mem_ack)
                        state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache that sits directly downstream of the MIPS core's data-memory port.
- Consumes the core's ram_cs/mem_ren/mem_wen/mem_addr/mem_dout and returns read data plus ram_stall.
- Converts misses and all writes into a req/ack handshake toward slow backing RAM.
- Read hits complete in zero extra cycles; everything else freezes the pipeline via stall.

Parameters:
LINES, 64, number of cache lines (power of two)
LINE_WORDS, 4, 32-bit words per line (power of two, >=2)
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  main clock
rst  input  1  reset; synchronous, active-low
cs  input  1  core data-memory chip select (ram_cs)
ren  input  1  core read enable
wen  input  1  core write enable
addr  input  ADDR_WIDTH  core byte address; bits [1:0] ignored
din  input  32  core write data
dout  output  32  read data to core
stall  output  1  to core ram_stall; core holds cs/ren/wen/addr/din stable while high
mem_req  output  1  backing-RAM request valid
mem_we  output  1  backing-RAM write (1) / read (0)
mem_addr  output  ADDR_WIDTH  backing-RAM word-aligned byte address
mem_wdata  output  32  backing-RAM write data
mem_rdata  input  32  backing-RAM read data, valid with mem_ack
mem_ack  input  1  backing-RAM completion, one cycle per word

Behaviour:
- Address split: word = addr[log2(LINE_WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: one valid bit, one tag and LINE_WORDS data words per line.
- FSM states: IDLE, FILL, WRITE, RESP.
- Reset (rst==0 at posedge):
  - state=IDLE; all valid bits cleared; fill counter=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dout=0.
  - stall is 0 while in reset.
  - Reset aborts FILL/WRITE mid-transaction; mem_req is low from the next cycle. Late mem_ack is ignored.
- IDLE, cs=0 or (ren=0 and wen=0): stall=0, no memory activity; dout holds its last value.
- IDLE, read hit (cs&ren&!wen, valid and tag match): dout = cached word combinationally, stall=0, state stays IDLE.
- IDLE, read miss:
  - stall=1 combinationally in the same cycle; next state FILL; counter=0.
  - Line valid bit is cleared on entry.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={tag,index,counter,2'b00}, held stable until mem_ack.
  - On mem_ack: write mem_rdata into word[counter]; counter++.
  - On the ack of the last word: set valid, write tag, go to RESP.
  - Words are fetched 0..LINE_WORDS-1 (no critical-word-first). stall=1 throughout.
- IDLE, write (cs&wen; wen has priority if ren also high):
  - stall=1; next state WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=word-aligned addr, mem_wdata=din.
  - On mem_ack: if hit, update the cached word with din (no allocate on miss); go to RESP.
- RESP: stall=0 for exactly one cycle; dout = cached word for a read (0-extra-latency view of the filled line); next state IDLE.
  - The core advances on this cycle; a new request is sampled only from IDLE on the following cycle.
  - RESP costs one bubble cycle per miss/write.
- mem_ack while mem_req=0 is ignored.
- Miss latency: 1 + sum of per-word ack latencies + 1 (RESP) cycles.
- Write latency: 1 + ack latency + 1 cycles.
- No byte/halfword writes; all accesses are full-word.

Decomposition:
- Shared header/package dcache_defs:
  - FSM state encoding (IDLE=0, FILL=1, WRITE=2, RESP=3).
  - Derived width constants: WORD_BITS, INDEX_BITS, TAG_BITS.
- One sub-module, dcache_store:
  - Valid/tag/data arrays with synchronous write and combinational read.
  - Outputs hit and rdata.
  - Synchronous active-low clear of the valid bits.
- dcache_ctrl holds the FSM, fill counter and memory handshake.

Test Plan:
1. After reset, read 0x0000_0040.
   - Backing RAM returns 0x11, 0x22, 0x33, 0x44, each acked 2 cycles after mem_req.
   - Expect mem_addr 0x40, 0x44, 0x48, 0x4C in order, stall=1 throughout.
   - RESP then gives dout=0x11, stall=0.
2. Then read 0x48 → same-cycle dout=0x33, stall=0, mem_req stays 0.
3. Write 0x44 with 0xDEADBEEF.
   - Expect mem_req=1, mem_we=1, mem_addr=0x44, mem_wdata=0xDEADBEEF until ack.
   - One RESP cycle follows.
   - Next read of 0x44 hits with dout=0xDEADBEEF and no mem_req.
4. Write-miss to 0x800, then read 0x800.
   - The write goes to RAM only.
   - The read misses and issues fills at 0x800..0x80C (no allocate on write).
5. Conflict: read 0x440 (same index 4 as 0x40, different tag) → refill. A following read of 0x40 misses again.
6. Reset mid-fill: drive rst=0 after the 2nd ack of a fill.
   - Expect mem_req=0 and stall=0 next cycle.
   - A late mem_ack changes nothing.
   - After release, a read of 0x40 misses.
